// File: rtl/gcl_ram_arbiter_pkg.sv
// Shared widths, RAM latency and read-return tag encoding for the
// gate-control / config RAM port arbiter.
package gcl_ram_arbiter_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int RAM_RD_LAT = 1;
  localparam int CNT_W      = 8;

  // One stage for the registered strobe plus one per RAM latency cycle.
  localparam int TAG_DEPTH  = RAM_RD_LAT + 1;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_GC   = 2'd1,
    TAG_CFG  = 2'd2
  } tag_e;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/gcl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module gcl_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gcl_ram_arbiter.sv
// Shares one single-port RAM between the gate-control reader and the config
// port; gate-control always wins, losing config requests wait in a pending slot.
module gcl_ram_arbiter
  import gcl_ram_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_wr,
  input  logic              i_cfg_rd,
  input  logic [ADDR_W-1:0] iv_cfg_addr,
  input  logic [DATA_W-1:0] iv_cfg_wdata,
  output logic              o_cfg_busy,
  output logic              o_cfg_rvalid,
  output logic [DATA_W-1:0] ov_cfg_rdata,
  input  logic              i_gc_rd,
  input  logic [ADDR_W-1:0] iv_gc_addr,
  output logic              o_gc_valid,
  output logic [DATA_W-1:0] ov_gc_rdata,
  output logic [ADDR_W-1:0] ov_ram_addr,
  output logic [DATA_W-1:0] ov_ram_wdata,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  input  logic [DATA_W-1:0] iv_ram_rdata,
  output logic [CNT_W-1:0]  ov_cfg_drop_cnt,
  output logic [CNT_W-1:0]  ov_gc_drop_cnt
);

  req_t gc_pend, gc_pend_next, cfg_pend, cfg_pend_next;
  req_t gc_new, cfg_new, gc_sel, cfg_sel, issue_sel;
  logic gc_issue, cfg_issue, any_issue;
  logic cfg_req, cfg_accept, cfg_drop, gc_drop;
  logic cfg_rd_in_flight, busy_next;
  tag_e issue_tag;
  tag_e tag_pipe [TAG_DEPTH];

  always_comb begin
    gc_new.valid  = i_gc_rd;
    gc_new.wr     = 1'b0;
    gc_new.addr   = iv_gc_addr;
    gc_new.wdata  = '0;

    // A simultaneous write+read keeps the write and drops the read.
    cfg_req       = i_cfg_wr | i_cfg_rd;
    cfg_accept    = cfg_req && !o_cfg_busy;
    cfg_drop      = (cfg_req && o_cfg_busy) || (i_cfg_wr && i_cfg_rd);
    cfg_new.valid = cfg_accept;
    cfg_new.wr    = i_cfg_wr;
    cfg_new.addr  = iv_cfg_addr;
    cfg_new.wdata = iv_cfg_wdata;

    gc_sel    = gc_pend.valid ? gc_pend : gc_new;
    cfg_sel   = cfg_pend.valid ? cfg_pend : cfg_new;
    gc_issue  = gc_sel.valid;
    cfg_issue = cfg_sel.valid && !gc_issue;
    any_issue = gc_issue || cfg_issue;
    issue_sel = gc_issue ? gc_sel : cfg_sel;
    gc_drop   = i_gc_rd && gc_pend.valid;

    gc_pend_next = gc_pend;
    if (gc_pend.valid && gc_issue) begin
      gc_pend_next.valid = 1'b0;
    end else if (!gc_pend.valid && gc_new.valid && !gc_issue) begin
      gc_pend_next = gc_new;
    end

    cfg_pend_next = cfg_pend;
    if (cfg_pend.valid && cfg_issue) begin
      cfg_pend_next.valid = 1'b0;
    end else if (!cfg_pend.valid && cfg_new.valid && !cfg_issue) begin
      cfg_pend_next = cfg_new;
    end

    if (gc_issue) begin
      issue_tag = TAG_GC;
    end else if (cfg_issue && !cfg_sel.wr) begin
      issue_tag = TAG_CFG;
    end else begin
      issue_tag = TAG_NONE;
    end

    // Busy drops in the cycle the config read data is presented.
    cfg_rd_in_flight = 1'b0;
    for (int i = 0; i < TAG_DEPTH - 1; i++) begin
      if (tag_pipe[i] == TAG_CFG) cfg_rd_in_flight = 1'b1;
    end
    busy_next = cfg_pend_next.valid || (issue_tag == TAG_CFG) || cfg_rd_in_flight;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gc_pend      <= '0;
      cfg_pend     <= '0;
      o_cfg_busy   <= 1'b0;
      o_ram_wr     <= 1'b0;
      o_ram_rd     <= 1'b0;
      ov_ram_addr  <= '0;
      ov_ram_wdata <= '0;
      o_gc_valid   <= 1'b0;
      ov_gc_rdata  <= '0;
      o_cfg_rvalid <= 1'b0;
      ov_cfg_rdata <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      gc_pend    <= gc_pend_next;
      cfg_pend   <= cfg_pend_next;
      o_cfg_busy <= busy_next;
      o_ram_wr   <= any_issue && issue_sel.wr;
      o_ram_rd   <= any_issue && !issue_sel.wr;
      if (any_issue) ov_ram_addr <= issue_sel.addr;
      if (any_issue && issue_sel.wr) ov_ram_wdata <= issue_sel.wdata;

      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < TAG_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];

      o_gc_valid   <= (tag_pipe[TAG_DEPTH-1] == TAG_GC);
      o_cfg_rvalid <= (tag_pipe[TAG_DEPTH-1] == TAG_CFG);
      if (tag_pipe[TAG_DEPTH-1] == TAG_GC)  ov_gc_rdata  <= iv_ram_rdata;
      if (tag_pipe[TAG_DEPTH-1] == TAG_CFG) ov_cfg_rdata <= iv_ram_rdata;
    end
  end

  gcl_sat_counter #(.WIDTH(CNT_W)) u_cfg_drop_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (1'b0),
    .inc   (cfg_drop),
    .count (ov_cfg_drop_cnt)
  );

  gcl_sat_counter #(.WIDTH(CNT_W)) u_gc_drop_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (1'b0),
    .inc   (gc_drop),
    .count (ov_gc_drop_cnt)
  );

endmodule

// File: tb/tb_gcl_ram_arbiter.sv
// Bench for gcl_ram_arbiter: behavioural RAM, cycle-scheduled reference model,
// directed scenarios plus a randomized run.
module tb_gcl_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0, cfg_rd = 1'b0, gc_rd = 1'b0;
  logic [9:0] cfg_addr = '0, gc_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic       cfg_busy, cfg_rvalid, gc_valid, ram_wr, ram_rd;
  logic [7:0] cfg_rdata, gc_rdata, ram_wdata, cfg_drop_cnt, gc_drop_cnt;
  logic [9:0] ram_addr;
  logic [7:0] ram_rdata = '0;

  always #4 clk = ~clk;

  gcl_ram_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_wr(cfg_wr), .i_cfg_rd(cfg_rd), .iv_cfg_addr(cfg_addr), .iv_cfg_wdata(cfg_wdata),
    .o_cfg_busy(cfg_busy), .o_cfg_rvalid(cfg_rvalid), .ov_cfg_rdata(cfg_rdata),
    .i_gc_rd(gc_rd), .iv_gc_addr(gc_addr), .o_gc_valid(gc_valid), .ov_gc_rdata(gc_rdata),
    .ov_ram_addr(ram_addr), .ov_ram_wdata(ram_wdata), .o_ram_wr(ram_wr), .o_ram_rd(ram_rd),
    .iv_ram_rdata(ram_rdata), .ov_cfg_drop_cnt(cfg_drop_cnt), .ov_gc_drop_cnt(gc_drop_cnt)
  );

  // Behavioural single-port RAM, one cycle read latency.
  logic [7:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_wr === 1'b1) ram_mem[ram_addr] <= ram_wdata;
    if (ram_rd === 1'b1) ram_rdata <= ram_mem[ram_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: each accepted operation schedules the output events it
  // causes into the cycle where they must appear.
  typedef struct {
    bit         rd, wr, gcv, cv;
    logic [9:0] addr;
    logic [7:0] wdata, gdata, cdata;
  } slot_t;

  slot_t      sched [8];
  logic [7:0] shadow [1024];
  bit         m_active, m_issued, m_wr;
  int         m_done;
  logic [9:0] m_addr, m_hold_addr;
  logic [7:0] m_wdata, m_hold_wdata;
  int         m_cfg_drops, m_gc_drops;

  bit         e_rd, e_wr, e_gcv, e_cv, e_busy;
  logic [9:0] e_addr;
  logic [7:0] e_wdata, e_gdata, e_cdata, e_cdrop, e_gdrop;

  function automatic bit model_busy(input int k);
    return m_active && (!m_issued || k < m_done);
  endfunction

  task automatic clear_slot(input int s);
    sched[s].rd = 0; sched[s].wr = 0; sched[s].gcv = 0; sched[s].cv = 0;
    sched[s].addr = '0; sched[s].wdata = '0; sched[s].gdata = '0; sched[s].cdata = '0;
  endtask

  task automatic model_step(input logic r, input logic g, input logic [9:0] ga,
                            input logic cw, input logic cr, input logic [9:0] ca,
                            input logic [7:0] cd);
    int  k = cyc;
    bit  busy;
    bit  gate_now = 0;
    int  s;
    if (!r) begin
      for (int i = 0; i < 8; i++) clear_slot(i);
      m_active = 0; m_issued = 0; m_cfg_drops = 0; m_gc_drops = 0;
      m_hold_addr = '0; m_hold_wdata = '0;
      return;
    end
    busy = model_busy(k);
    if (g) begin
      gate_now = 1;
      s = (k + 1) % 8; sched[s].rd = 1; sched[s].addr = ga;
      s = (k + 3) % 8; sched[s].gcv = 1; sched[s].gdata = shadow[ga];
    end
    if (cw || cr) begin
      if (busy) begin
        m_cfg_drops++;
      end else begin
        if (cw && cr) m_cfg_drops++;
        m_active = 1; m_issued = 0; m_wr = cw; m_addr = ca; m_wdata = cd;
      end
    end
    if (m_active && !m_issued && !gate_now) begin
      m_issued = 1;
      s = (k + 1) % 8;
      sched[s].addr = m_addr;
      if (m_wr) begin
        sched[s].wr = 1; sched[s].wdata = m_wdata;
        shadow[m_addr] = m_wdata;
        m_done = k + 1;
      end else begin
        sched[s].rd = 1;
        sched[(k + 3) % 8].cv = 1; sched[(k + 3) % 8].cdata = shadow[m_addr];
        m_done = k + 3;
      end
    end
  endtask

  task automatic model_view();
    int s = cyc % 8;
    e_rd = sched[s].rd; e_wr = sched[s].wr; e_gcv = sched[s].gcv; e_cv = sched[s].cv;
    e_gdata = sched[s].gdata; e_cdata = sched[s].cdata;
    if (e_rd || e_wr) m_hold_addr = sched[s].addr;
    if (e_wr) m_hold_wdata = sched[s].wdata;
    e_addr = m_hold_addr; e_wdata = m_hold_wdata;
    e_busy = model_busy(cyc);
    e_cdrop = (m_cfg_drops > 255) ? 8'd255 : 8'(m_cfg_drops);
    e_gdrop = (m_gc_drops > 255) ? 8'd255 : 8'(m_gc_drops);
    clear_slot(s);
  endtask

  // One clock: apply inputs for this cycle, advance model, sample after the edge.
  task automatic drive(input logic r, input logic g, input logic [9:0] ga,
                       input logic cw, input logic cr, input logic [9:0] ca,
                       input logic [7:0] cd);
    rst_n = r; gc_rd = g; gc_addr = ga; cfg_wr = cw; cfg_rd = cr;
    cfg_addr = ca; cfg_wdata = cd;
    model_step(r, g, ga, cw, cr, ca, cd);
    @(posedge clk);
    #1;
    cyc++;
    model_view();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    ram_mem[a] = v;
    shadow[a] = v;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom),
            10'($urandom), 8'($urandom));
      checks++;
      if ({cfg_busy, cfg_rvalid, cfg_rdata, gc_valid, gc_rdata, ram_addr, ram_wdata,
           ram_wr, ram_rd, cfg_drop_cnt, gc_drop_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: busy=%b rv=%b gv=%b wr=%b rd=%b addr=%h cdrop=%0d, required all zero",
                 cfg_busy, cfg_rvalid, gc_valid, ram_wr, ram_rd, ram_addr, cfg_drop_cnt);
      end
    end
    idle();
  endtask

  task automatic test_gate_read();
    preload(5, 8'h3C);
    drive(1'b1, 1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
    checks++;
    if ({ram_rd, ram_wr, ram_addr} !== {1'b1, 1'b0, 10'h005}) begin
      failures++;
      $display("FAIL gate_issue: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=005", ram_rd, ram_wr, ram_addr);
    end
    idle();
    checks++;
    if (gc_valid !== 1'b0) begin
      failures++;
      $display("FAIL gate_early_valid: got %b required 0", gc_valid);
    end
    idle();
    checks++;
    if ({gc_valid, gc_rdata} !== {1'b1, 8'h3C}) begin
      failures++;
      $display("FAIL gate_return: valid=%b data=%h, required valid=1 data=3c", gc_valid, gc_rdata);
    end
    idle();
    checks++;
    if (gc_valid !== 1'b0) begin
      failures++;
      $display("FAIL gate_single_pulse: got %b required 0", gc_valid);
    end
  endtask

  task automatic test_write_vs_gate();
    preload(16, 8'h5A);
    drive(1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 10'h010, 8'hA5);
    checks++;
    if ({ram_rd, ram_wr, ram_addr, cfg_busy} !== {1'b1, 1'b0, 10'h010, 1'b1}) begin
      failures++;
      $display("FAIL collide_t1: rd=%b wr=%b addr=%h busy=%b, required 1 0 010 1", ram_rd, ram_wr, ram_addr, cfg_busy);
    end
    idle();
    checks++;
    if ({ram_rd, ram_wr, ram_addr, ram_wdata, cfg_busy} !== {1'b0, 1'b1, 10'h010, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL collide_t2: rd=%b wr=%b addr=%h wdata=%h busy=%b, required 0 1 010 a5 0",
               ram_rd, ram_wr, ram_addr, ram_wdata, cfg_busy);
    end
    idle();
    checks++;
    if ({gc_valid, gc_rdata, cfg_busy} !== {1'b1, 8'h5A, 1'b0}) begin
      failures++;
      $display("FAIL collide_old_data: valid=%b data=%h busy=%b, required 1 5a 0", gc_valid, gc_rdata, cfg_busy);
    end
    drive(1'b1, 1'b1, 10'h010, 1'b0, 1'b0, '0, '0);
    idle(); idle();
    checks++;
    if ({gc_valid, gc_rdata} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL collide_new_data: valid=%b data=%h, required 1 a5", gc_valid, gc_rdata);
    end
  endtask

  task automatic test_back_to_back();
    preload(32, 8'hC3);
    preload(48, 8'h96);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 10'h020, '0);
    drive(1'b1, 1'b1, 10'h030, 1'b0, 1'b0, '0, '0);
    idle();
    checks++;
    if ({cfg_rvalid, cfg_rdata, gc_valid} !== {1'b1, 8'hC3, 1'b0}) begin
      failures++;
      $display("FAIL b2b_cfg: rvalid=%b data=%h gvalid=%b, required 1 c3 0", cfg_rvalid, cfg_rdata, gc_valid);
    end
    idle();
    checks++;
    if ({gc_valid, gc_rdata, cfg_rvalid} !== {1'b1, 8'h96, 1'b0}) begin
      failures++;
      $display("FAIL b2b_gc: gvalid=%b data=%h rvalid=%b, required 1 96 0", gc_valid, gc_rdata, cfg_rvalid);
    end
  endtask

  task automatic test_drop_saturation();
    int wr_seen = 0;
    int rd_seen = 0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 10'($urandom), 1'b1, 1'b0, 10'h040, 8'h77);
    wr_seen += int'(ram_wr === 1'b1); rd_seen += int'(ram_rd === 1'b1);
    for (int n = 1; n <= 300; n++) begin
      logic w;
      w = 1'($urandom);
      drive(1'b1, 1'b1, 10'($urandom), w, ~w | 1'($urandom), 10'($urandom), 8'($urandom));
      wr_seen += int'(ram_wr === 1'b1); rd_seen += int'(ram_rd === 1'b1);
      if (n == 100 || n == 255) begin
        checks++;
        if (cfg_drop_cnt !== 8'(n)) begin
          failures++;
          $display("FAIL drop_count_%0d: got %0d required %0d", n, cfg_drop_cnt, n);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      wr_seen += int'(ram_wr === 1'b1); rd_seen += int'(ram_rd === 1'b1);
    end
    checks++;
    if (cfg_drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL drop_saturate: got %0d required 255", cfg_drop_cnt);
    end
    checks++;
    if (wr_seen != 1 || rd_seen != 301) begin
      failures++;
      $display("FAIL drop_ram_ops: writes=%0d reads=%0d, required writes=1 reads=301", wr_seen, rd_seen);
    end
    checks++;
    if (gc_drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL gc_drop_count: got %0d required 0", gc_drop_cnt);
    end
  endtask

  task automatic test_reset_in_flight();
    preload(5, 8'h3C);
    drive(1'b1, 1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++;
      if ({gc_valid, cfg_rvalid, cfg_busy, cfg_drop_cnt, gc_drop_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_flush_%0d: gv=%b cv=%b busy=%b cdrop=%0d gdrop=%0d, required all zero",
                 i, gc_valid, cfg_rvalid, cfg_busy, cfg_drop_cnt, gc_drop_cnt);
      end
    end
    test_gate_read();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      logic r, g, w, rd;
      r  = ($urandom_range(0, 199) != 0);
      g  = ($urandom_range(0, 99) < 45);
      w  = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 30);
      drive(r, g, 10'($urandom_range(0, 15)), w, rd, 10'($urandom_range(0, 15)), 8'($urandom));
      checks++;
      if ({ram_rd, ram_wr, gc_valid, cfg_rvalid, cfg_busy} !== {e_rd, e_wr, e_gcv, e_cv, e_busy}) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d: rd,wr,gv,cv,busy=%b required %b", cyc,
                 {ram_rd, ram_wr, gc_valid, cfg_rvalid, cfg_busy}, {e_rd, e_wr, e_gcv, e_cv, e_busy});
      end
      checks++;
      if ({ram_addr, ram_wdata} !== {e_addr, e_wdata}) begin
        failures++;
        $display("FAIL rand_ram_bus cyc=%0d: addr=%h wdata=%h required %h %h", cyc, ram_addr, ram_wdata, e_addr, e_wdata);
      end
      if (e_gcv) begin
        checks++;
        if (gc_rdata !== e_gdata) begin
          failures++;
          $display("FAIL rand_gc_data cyc=%0d: got %h required %h", cyc, gc_rdata, e_gdata);
        end
      end
      if (e_cv) begin
        checks++;
        if (cfg_rdata !== e_cdata) begin
          failures++;
          $display("FAIL rand_cfg_data cyc=%0d: got %h required %h", cyc, cfg_rdata, e_cdata);
        end
      end
      checks++;
      if ({cfg_drop_cnt, gc_drop_cnt} !== {e_cdrop, e_gdrop}) begin
        failures++;
        $display("FAIL rand_drops cyc=%0d: cfg=%0d gc=%0d required %0d %0d", cyc, cfg_drop_cnt, gc_drop_cnt, e_cdrop, e_gdrop);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 8'($urandom);
      shadow[i] = ram_mem[i];
    end
    for (int i = 0; i < 8; i++) clear_slot(i);
    m_active = 0; m_issued = 0; m_wr = 0; m_done = 0; m_addr = '0; m_wdata = '0;
    m_hold_addr = '0; m_hold_wdata = '0; m_cfg_drops = 0; m_gc_drops = 0;

    test_reset();
    test_gate_read();
    test_write_vs_gate();
    test_back_to_back();
    test_drop_saturation();
    test_reset_in_flight();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
